// File: rtl/cfs_md_source.sv
// MD-protocol initiator: queues data/offset/size/gap commands and
// replays each one as a single MD transfer towards an aligner RX port.
module cfs_md_source #(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int CMD_DEPTH       = 4,
    localparam int OW = $clog2(ALGN_DATA_WIDTH / 8),
    localparam int SW = $clog2(ALGN_DATA_WIDTH / 8) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ALGN_DATA_WIDTH-1:0] cmd_data,
    input  logic [OW-1:0]              cmd_offset,
    input  logic [SW-1:0]              cmd_size,
    input  logic [3:0]                 cmd_gap,
    output logic                       md_valid,
    output logic [ALGN_DATA_WIDTH-1:0] md_data,
    output logic [OW-1:0]              md_offset,
    output logic [SW-1:0]              md_size,
    input  logic                       md_ready,
    input  logic                       md_err,
    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [15:0]                sent_cnt,
    output logic [15:0]                err_cnt,
    input  logic                       clr_cnt,
    output logic                       busy
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ALGN_DATA_WIDTH-1:0] data;
        logic [OW-1:0]              offset;
        logic [SW-1:0]              size;
        logic [3:0]                 gap;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        DRIVE
    } state_t;

    cmd_t                       mem_q [CMD_DEPTH];
    cmd_t                       wr_entry;
    cmd_t                       head;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       ne_q, ne_d;
    state_t                     state_q, state_d;
    logic [3:0]                 gap_q, gap_d;
    logic [ALGN_DATA_WIDTH-1:0] data_q, data_d;
    logic [OW-1:0]              offset_q, offset_d;
    logic [SW-1:0]              size_q, size_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_err_q, rsp_err_d;
    logic [15:0]                sent_q, sent_d;
    logic [15:0]                err_q, err_d;
    logic                       push;
    logic                       pop;
    logic                       hs;
    logic                       fifo_ne;

    assign fifo_ne   = (cnt_q != '0);
    assign cmd_ready = (cnt_q != CW'(CMD_DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign hs        = (state_q == DRIVE) & md_ready;

    always_comb begin
        wr_entry        = '0;
        wr_entry.data   = cmd_data;
        wr_entry.offset = cmd_offset;
        wr_entry.size   = cmd_size;
        wr_entry.gap    = cmd_gap;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ne_d     = fifo_ne;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // From IDLE a fresh entry launches only after it has been resident for
    // a full cycle (ne_q); in DRIVE the live count allows back-to-back pops.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        data_d   = data_q;
        offset_d = offset_q;
        size_d   = size_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ne_q && fifo_ne) begin
                    pop = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == 4'd1) begin
                    state_d = DRIVE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            DRIVE: begin
                if (md_ready) begin
                    if (fifo_ne) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            data_d   = head.data;
            offset_d = head.offset;
            size_d   = head.size;
            gap_d    = head.gap;
            state_d  = (head.gap == 4'd0) ? DRIVE : GAP;
        end
    end

    always_comb begin
        sent_d      = sent_q;
        err_d       = err_q;
        rsp_valid_d = hs;
        rsp_err_d   = hs & md_err;
        if (clr_cnt) begin
            sent_d = '0;
            err_d  = '0;
        end else if (hs) begin
            if (sent_q != 16'hFFFF) begin
                sent_d = sent_q + 16'd1;
            end
            if (md_err && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ne_q        <= 1'b0;
            state_q     <= IDLE;
            gap_q       <= '0;
            data_q      <= '0;
            offset_q    <= '0;
            size_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            sent_q      <= '0;
            err_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ne_q        <= ne_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            sent_q      <= sent_d;
            err_q       <= err_d;
        end
    end

    assign md_valid  = (state_q == DRIVE);
    assign md_data   = data_q;
    assign md_offset = offset_q;
    assign md_size   = size_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign sent_cnt  = sent_q;
    assign err_cnt   = err_q;
    assign busy      = fifo_ne | (state_q != IDLE);

endmodule

// File: tb/tb_cfs_md_source.sv
// Directed bench for cfs_md_source: a scoreboard queue holds the
// transfers and responses expected from every accepted command.
module tb_cfs_md_source;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_offset;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_gap;
    logic        md_valid;
    logic [31:0] md_data;
    logic [1:0]  md_offset;
    logic [2:0]  md_size;
    logic        md_ready;
    logic        md_err;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] sent_cnt;
    logic [15:0] err_cnt;
    logic        clr_cnt;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  off;
        logic [2:0]  size;
    } exp_t;

    exp_t exp_q[$];
    logic rsp_q[$];

    cfs_md_source #(
        .ALGN_DATA_WIDTH(32),
        .CMD_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_offset(cmd_offset),
        .cmd_size  (cmd_size),
        .cmd_gap   (cmd_gap),
        .md_valid  (md_valid),
        .md_data   (md_data),
        .md_offset (md_offset),
        .md_size   (md_size),
        .md_ready  (md_ready),
        .md_err    (md_err),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .sent_cnt  (sent_cnt),
        .err_cnt   (err_cnt),
        .clr_cnt   (clr_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] d, input logic [1:0] o,
                            input logic [2:0] s, input logic [3:0] g);
        exp_t e;
        cmd_data   = d;
        cmd_offset = o;
        cmd_size   = s;
        cmd_gap    = g;
        cmd_valid  = 1'b1;
        chk("push_ready", {31'd0, cmd_ready}, 32'd1);
        e.data = d;
        e.off  = o;
        e.size = s;
        exp_q.push_back(e);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!md_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, md_valid}, 32'd1);
    endtask

    // Monitor: retire expected transfers on each handshake and check
    // the response that must follow one cycle later.
    always @(negedge clk) begin
        exp_t c;
        logic e;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_extra", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e});
            end
        end
        if (md_valid && md_ready) begin
            if (exp_q.size() == 0) begin
                chk("md_extra", {31'd0, md_valid}, 32'd0);
            end else begin
                c = exp_q.pop_front();
                chk("md_data", md_data, c.data);
                chk("md_offset", {30'd0, md_offset}, {30'd0, c.off});
                chk("md_size", {29'd0, md_size}, {29'd0, c.size});
            end
            rsp_q.push_back(md_err);
        end
    end

    initial begin
        int vcnt;
        int run;
        int k;
        int pat[7];
        pat = '{0, 0, 0, 0, 0, 1, 0};
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_offset = '0;
        cmd_size   = '0;
        cmd_gap    = '0;
        md_ready   = 1'b0;
        md_err     = 1'b0;
        clr_cnt    = 1'b0;

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_md_valid", {31'd0, md_valid}, 32'd0);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_sent", {16'd0, sent_cnt}, 32'd0);
        chk("t1_err", {16'd0, err_cnt}, 32'd0);
        chk("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // T2 single transfer, latency E+2
        md_ready = 1'b1;
        push_cmd(32'hAABBCCDD, 2'd1, 3'd2, 4'd0);
        @(negedge clk);
        chk("t2_lat_e0", {31'd0, md_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("t2_lat_e1", {31'd0, md_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("t2_valid", {31'd0, md_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("t2_drop", {31'd0, md_valid}, 32'd0);
        chk("t2_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("t2_sent", {16'd0, sent_cnt}, 32'd1);
        tick();

        // T3 backpressure
        md_ready = 1'b0;
        push_cmd(32'h11223344, 2'd0, 3'd4, 4'd0);
        wait_valid("t3_wait");
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            vcnt += int'(md_valid);
            chk("t3_stable", md_data, 32'h11223344);
            tick();
            if (i == 4) md_ready = 1'b1;
            @(negedge clk);
        end
        vcnt += int'(md_valid);
        tick();
        @(negedge clk);
        chk("t3_vcnt", vcnt, 32'd6);
        chk("t3_drop", {31'd0, md_valid}, 32'd0);
        chk("t3_rsp", {31'd0, rsp_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("t3_rsp_once", {31'd0, rsp_valid}, 32'd0);
        chk("t3_sent", {16'd0, sent_cnt}, 32'd2);

        // clear counters before streaming
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_sent", {16'd0, sent_cnt}, 32'd0);
        tick();

        // T4 fill: one entry stalls in DRIVE, four fill the FIFO
        md_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(32'hC0DE0000 + i, 2'(i), 3'd4, 4'd0);
        end
        @(negedge clk);
        chk("t4_full", {31'd0, cmd_ready}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        cmd_data  = 32'hDEADBEEF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        md_ready  = 1'b1;
        run = 0;
        k = 0;
        @(negedge clk);
        while (md_valid && k < 20) begin
            run++;
            k++;
            @(negedge clk);
        end
        chk("t4_run", run, 32'd5);
        chk("t4_sent", {16'd0, sent_cnt}, 32'd5);
        tick();

        // T5 gap of 3
        push_cmd(32'h5A5A5A5A, 2'd2, 3'd1, 4'd3);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("t5_pat%0d", i), {31'd0, md_valid}, pat[i]);
        end
        tick();

        // T6 error response, then clear colliding with a completion
        md_err = 1'b1;
        push_cmd(32'h0F0F0F0F, 2'd3, 3'd2, 4'd0);
        wait_valid("t6_wait");
        tick();
        @(negedge clk);
        chk("t6_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("t6_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("t6_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("t6_sent", {16'd0, sent_cnt}, 32'd7);
        tick();
        push_cmd(32'h12345678, 2'd0, 3'd0, 4'd0);
        wait_valid("t6_wait2");
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("t6_clr_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("t6_clr_sent", {16'd0, sent_cnt}, 32'd0);
        chk("t6_clr_err", {16'd0, err_cnt}, 32'd0);
        tick();
        md_err = 1'b0;

        // reset while a transfer is stalled
        md_ready = 1'b0;
        tick();
        push_cmd(32'hCAFEF00D, 2'd1, 3'd3, 4'd0);
        wait_valid("rst_wait");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_md_valid", {31'd0, md_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        md_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("rst_no_replay", {31'd0, md_valid}, 32'd0);

        k = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && k < 20) begin
            tick();
            k++;
        end
        chk("end_exp_q", exp_q.size(), 32'd0);
        chk("end_rsp_q", rsp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
